// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter
//   Shares program-memory read port B among NUM_REQ requesters. One request
//   is granted per cycle (round-robin) and issued as a registered read. A
//   one-hot tag pipeline, LATENCY stages behind the issue register, routes
//   each returned word back to the requester that asked for it.
//   Grants are held off until program memory reports init done.
//
//   Optional build macro PMEM_ARB_FIXED_PRIO_EN: requester 0 always wins when
//   valid (pointer untouched); requesters 1..NUM_REQ-1 rotate round-robin.
//
// Ports
//   clk_in, rst_in          clock, async active-high reset
//   mem_ready_in            program memory init done (level)
//   req_valid_in/addr_in    per-requester read request and byte address
//   req_ready_out           one-hot grant (handshake = valid & ready)
//   rsp_valid_out           one-hot response strobe
//   rsp_data_out            response word, broadcast
//   mem_addr_out            port B address (registered)
//   mem_read_request_out    port B read strobe (registered)
//   mem_instr_in            port B data
//   mem_data_valid_in       port B data valid
//   error_out               sticky: data valid with no tag in flight
module program_memory_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      mem_ready_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    output logic [NUM_REQ-1:0]        rsp_valid_out,
    output logic [DATA_W-1:0]         rsp_data_out,
    output logic [ADDR_W-1:0]         mem_addr_out,
    output logic                      mem_read_request_out,
    input  logic [DATA_W-1:0]         mem_instr_in,
    input  logic                      mem_data_valid_in,
    output logic                      error_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

`ifdef PMEM_ARB_FIXED_PRIO_EN
    // Requester 0 is served by the priority check, not by the rotation.
    localparam logic [NUM_REQ-1:0] RR_MASK = {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
    localparam logic [NUM_REQ-1:0] RR_MASK = {NUM_REQ{1'b1}};
`endif

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
    logic [PTR_W-1:0]               ptr, ptr_nxt, gidx;
    logic [NUM_REQ-1:0]             grant;
    logic                           hs;
    // tag_pipe[0] is loaded together with mem_read_request_out; tag_pipe[LATENCY]
    // lines up with the memory's data valid.
    logic [LATENCY:0][NUM_REQ-1:0]  tag_pipe;
    logic [NUM_REQ-1:0]             tag_out;

    assign addr_arr = req_addr_in;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // First valid requester at or after ptr, with wrap-around.
    always_comb begin
        grant = '0;
        gidx  = '0;
`ifdef PMEM_ARB_FIXED_PRIO_EN
        if (req_valid_in[0]) grant[0] = 1'b1;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == '0 && req_valid_in[wrap_idx(ptr, k)] && RR_MASK[wrap_idx(ptr, k)]) begin
                grant[wrap_idx(ptr, k)] = 1'b1;
                gidx = wrap_idx(ptr, k);
            end
        end
    end

    // Ready is forced low during reset so every output is quiet while rst_in is high.
    assign req_ready_out = grant & {NUM_REQ{mem_ready_in & ~rst_in}};
    assign hs            = |req_ready_out;

    always_comb begin
        ptr_nxt = ptr;
`ifdef PMEM_ARB_FIXED_PRIO_EN
        if (hs && !grant[0]) ptr_nxt = (gidx == LAST) ? '0 : gidx + 1'b1;
`else
        if (hs) ptr_nxt = (gidx == LAST) ? '0 : gidx + 1'b1;
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr                  <= '0;
            mem_read_request_out <= 1'b0;
            mem_addr_out         <= '0;
            tag_pipe             <= '0;
            error_out            <= 1'b0;
        end else begin
            ptr                  <= ptr_nxt;
            mem_read_request_out <= hs;
            if (hs) mem_addr_out <= addr_arr[gidx];
            tag_pipe             <= {tag_pipe[LATENCY-1:0], req_ready_out};
            if (mem_data_valid_in && tag_out == '0) error_out <= 1'b1;
        end
    end

    assign tag_out       = tag_pipe[LATENCY];
    assign rsp_valid_out = tag_out & {NUM_REQ{mem_data_valid_in}};
    assign rsp_data_out  = mem_instr_in;

endmodule

// File: tb/tb_program_memory_arbiter.sv
module tb_program_memory_arbiter;
    localparam int N = 4, LAT = 2, AW = 32, DW = 32;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              mem_ready_in;
    logic [N-1:0]      req_valid_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N-1:0]      req_ready_out, rsp_valid_out;
    logic [DW-1:0]     rsp_data_out;
    logic [AW-1:0]     mem_addr_out;
    logic              mem_read_request_out;
    logic [DW-1:0]     mem_instr_in;
    logic              mem_data_valid_in;
    logic              error_out;
    logic              force_dv;

    program_memory_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_ready_in(mem_ready_in),
        .req_valid_in(req_valid_in), .req_addr_in(req_addr_in),
        .req_ready_out(req_ready_out), .rsp_valid_out(rsp_valid_out),
        .rsp_data_out(rsp_data_out), .mem_addr_out(mem_addr_out),
        .mem_read_request_out(mem_read_request_out), .mem_instr_in(mem_instr_in),
        .mem_data_valid_in(mem_data_valid_in), .error_out(error_out));

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Memory model: fixed-latency port B, valid pipeline reset by rst_in.
    logic [LAT:1]         mv;
    logic [LAT:1][DW-1:0] md;
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mv <= '0;
            md <= '0;
        end else begin
            mv[1] <= mem_read_request_out;
            md[1] <= mem_word(mem_addr_out);
            for (int k = 2; k <= LAT; k++) begin
                mv[k] <= mv[k-1];
                md[k] <= md[k-1];
            end
        end
    end
    assign mem_data_valid_in = mv[LAT] | force_dv;
    assign mem_instr_in      = md[LAT];

    int errors = 0, checks = 0, cyc = 0, rsp_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on handshake, pop when a response appears.
    typedef struct { int req; logic [DW-1:0] data; int cyc; } exp_t;
    exp_t sb[$];

    always @(negedge clk_in) begin
        exp_t e;
        cyc++;
        if (rst_in) sb.delete();
        else begin
            if (rsp_valid_out != '0) begin
                rsp_seen++;
                if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_out), 32'h0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_onehot", 32'(rsp_valid_out), 32'(1 << e.req));
                    chk("rsp_data", rsp_data_out, e.data);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 32'(rsp_valid_out), 32'(1 << e.req));
            end
            for (int i = 0; i < N; i++)
                if (req_valid_in[i] && req_ready_out[i])
                    sb.push_back('{i, mem_word(req_addr_in[i*AW +: AW]), cyc + 1 + LAT});
        end
    end

    typedef struct { logic [N-1:0] valid; logic mrdy; logic [N-1:0] exp; } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [N-1:0] v, input logic m, input logic [N-1:0] e);
        vec_t t;
        t.valid = v; t.mrdy = m; t.exp = e;
        tbl.push_back(t);
    endfunction

    logic [N-1:0][AW-1:0] a;

    task automatic drive_addrs();
        for (int i = 0; i < N; i++) a[i] = $urandom & 32'hFFFF_FFFC;
        a[2] = 32'h0000_0104;
        req_addr_in = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] last_addr;
        logic          prev_hs;
        int            snap;

        rst_in = 1'b1; mem_ready_in = 1'b1; req_valid_in = '1; force_dv = 1'b0;
        drive_addrs();
        repeat (2) @(negedge clk_in);
        chk("rst_ready", 32'(req_ready_out), 32'h0);
        chk("rst_rsp", 32'(rsp_valid_out), 32'h0);
        chk("rst_memreq", 32'(mem_read_request_out), 32'h0);
        chk("rst_addr", mem_addr_out, 32'h0);
        chk("rst_err", 32'(error_out), 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b0; req_valid_in = '0;

`ifdef PMEM_ARB_FIXED_PRIO_EN
        add(4'b1111, 1'b0, 4'b0000);
        add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0001);
        add(4'b0011, 1'b1, 4'b0001); add(4'b0011, 1'b1, 4'b0001);
        add(4'b0010, 1'b1, 4'b0010); add(4'b1110, 1'b1, 4'b0100);
        add(4'b1010, 1'b1, 4'b1000); add(4'b1010, 1'b1, 4'b0010);
        add(4'b1011, 1'b0, 4'b0000); add(4'b0000, 1'b1, 4'b0000);
`else
        add(4'b1111, 1'b0, 4'b0000);
        add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0010);
        add(4'b1111, 1'b1, 4'b0100); add(4'b1111, 1'b1, 4'b1000);
        add(4'b1111, 1'b1, 4'b0001); add(4'b1111, 1'b1, 4'b0010);
        add(4'b1111, 1'b1, 4'b0100); add(4'b1111, 1'b1, 4'b1000);
        add(4'b0000, 1'b1, 4'b0000); add(4'b0100, 1'b1, 4'b0100);
        add(4'b0000, 1'b1, 4'b0000); add(4'b0010, 1'b1, 4'b0010);
        add(4'b1010, 1'b1, 4'b1000); add(4'b1010, 1'b1, 4'b0010);
        add(4'b1010, 1'b0, 4'b0000); add(4'b0000, 1'b1, 4'b0000);
`endif

        last_addr = '0;
        prev_hs   = 1'b0;
        foreach (tbl[r]) begin
            @(posedge clk_in); #1;
            req_valid_in = tbl[r].valid;
            mem_ready_in = tbl[r].mrdy;
            drive_addrs();
            @(negedge clk_in);
            chk($sformatf("grant_row%0d", r), 32'(req_ready_out), 32'(tbl[r].exp));
            chk($sformatf("memreq_row%0d", r), 32'(mem_read_request_out), 32'(prev_hs));
            chk($sformatf("memaddr_row%0d", r), mem_addr_out, last_addr);
            prev_hs = (tbl[r].exp != '0);
            for (int i = 0; i < N; i++) if (tbl[r].exp[i]) last_addr = a[i];
        end

        // Drain: every in-flight read must come back.
        @(posedge clk_in); #1;
        req_valid_in = '0; mem_ready_in = 1'b1;
        repeat (LAT + 4) @(negedge clk_in);
        chk("drain_empty", 32'(sb.size()), 32'h0);

        // Data valid with nothing in flight: sticky error, no response.
        @(posedge clk_in); #1; force_dv = 1'b1;
        @(negedge clk_in);
        chk("err_no_rsp", 32'(rsp_valid_out), 32'h0);
        @(posedge clk_in); #1; force_dv = 1'b0;
        @(negedge clk_in);
        chk("err_set", 32'(error_out), 32'h1);
        repeat (3) @(negedge clk_in);
        chk("err_sticky", 32'(error_out), 32'h1);
        chk("err_no_rsp2", 32'(rsp_valid_out), 32'h0);

        // Reset with two reads in flight.
        @(posedge clk_in); #1; req_valid_in = 4'b0001; drive_addrs();
        @(posedge clk_in); #1; req_valid_in = 4'b0010; drive_addrs();
        @(posedge clk_in); #1; req_valid_in = '1;
        rst_in = 1'b1;
        #1;
        chk("arst_ready", 32'(req_ready_out), 32'h0);
        chk("arst_rsp", 32'(rsp_valid_out), 32'h0);
        chk("arst_memreq", 32'(mem_read_request_out), 32'h0);
        chk("arst_addr", mem_addr_out, 32'h0);
        chk("arst_err", 32'(error_out), 32'h0);
        req_valid_in = '0;
        snap = rsp_seen;
        repeat (2) @(posedge clk_in);
        #1; rst_in = 1'b0;
        repeat (6) @(negedge clk_in);
        chk("no_rsp_after_rst", rsp_seen, snap);
        chk("no_err_after_rst", 32'(error_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
